// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared widths and types for the common data bus (CDB) arbiter.
//   DATA_W_DEF / ROB_W_DEF : default result width and ROB tag width
//   cdb_entry_w()          : width of one packed {rob_id, value} CDB entry
//   rr_e                   : round-robin pointer, which source wins a tie
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ROB_W_DEF  = 4;

    typedef enum logic {
        RR_ALU_FIRST = 1'b0,
        RR_LSB_FIRST = 1'b1
    } rr_e;

    // A CDB entry is packed as {rob_id, value}.
    function automatic int cdb_entry_w(input int data_w, input int rob_w);
        return data_w + rob_w;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bus bundle between the two result producers, the arbiter and the CDB
// consumers.
//   alu_valid/alu_val/alu_rob_id : ALU result offer      (producer -> arbiter)
//   alu_ready                    : ALU offer accepted    (arbiter -> producer)
//   lsb_valid/lsb_val/lsb_rob_id : load result offer     (producer -> arbiter)
//   lsb_ready                    : load offer accepted   (arbiter -> producer)
//   cdb_valid/cdb_val/cdb_rob_id : registered broadcast  (arbiter -> consumers)
// Modports: slave = arbiter side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4
) ();

    logic              alu_valid;
    logic [DATA_W-1:0] alu_val;
    logic [ROB_W-1:0]  alu_rob_id;
    logic              alu_ready;

    logic              lsb_valid;
    logic [DATA_W-1:0] lsb_val;
    logic [ROB_W-1:0]  lsb_rob_id;
    logic              lsb_ready;

    logic              cdb_valid;
    logic [DATA_W-1:0] cdb_val;
    logic [ROB_W-1:0]  cdb_rob_id;

    modport slave (
        input  alu_valid, alu_val, alu_rob_id,
        output alu_ready,
        input  lsb_valid, lsb_val, lsb_rob_id,
        output lsb_ready,
        output cdb_valid, cdb_val, cdb_rob_id
    );

    modport master (
        output alu_valid, alu_val, alu_rob_id,
        input  alu_ready,
        output lsb_valid, lsb_val, lsb_rob_id,
        input  lsb_ready,
        input  cdb_valid, cdb_val, cdb_rob_id
    );

endinterface

// File: rtl/cdb_arbiter_slot.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_slot
// One-entry holding register for a producer that lost CDB arbitration.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : global enable; low freezes the slot
//   flush_i      : empty the slot (misprediction flush), highest priority
//   load_i       : capture d_i and mark the slot occupied
//   drain_i      : slot contents were broadcast; mark empty
//   d_i          : entry to capture
//   valid_o/q_o  : slot occupied flag and held entry
// Load beats drain so a slot that is broadcast and refilled in the same cycle
// ends up holding the new entry.
// -----------------------------------------------------------------------------
module cdb_arbiter_slot #(
    parameter int W = 36
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         flush_i,
    input  logic         load_i,
    input  logic         drain_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = d_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Shares the common data bus between the ALU and the load/store buffer.
// Each source owns a one-entry holding slot so a loser is kept, not dropped;
// a round-robin pointer breaks ties and flips after every contested grant.
// The winner appears on the CDB one cycle later (registered outputs).
//   clk_i       : clock
//   rst_i       : synchronous active-high reset (dominates rdy_i/is_clear_i)
//   rdy_i       : global enable; low freezes all state and drops both readies
//   is_clear_i  : misprediction flush; empties slots, kills the next broadcast
//   bus         : producer offers, ready handshakes and CDB broadcast
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ROB_W  = ROB_W_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          rdy_i,
    input  logic          is_clear_i,
    cdb_arbiter_if.slave  bus
);

    localparam int ENTRY_W = cdb_entry_w(DATA_W, ROB_W);

    logic               accept_en;
    logic [ENTRY_W-1:0] alu_in, lsb_in;
    logic               slot_alu_v, slot_lsb_v;
    logic [ENTRY_W-1:0] slot_alu_q, slot_lsb_q;

    logic               cand_alu, cand_lsb;
    logic [ENTRY_W-1:0] cand_alu_entry, cand_lsb_entry;
    logic               grant_alu, grant_lsb;
    logic               alu_ready, lsb_ready;
    logic               alu_accept, lsb_accept;

    rr_e                rr_q, rr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [ENTRY_W-1:0] cdb_entry_q, cdb_entry_d;

    // Arbitration and acceptance only happen in a live, non-flush cycle.
    assign accept_en = rdy_i & ~rst_i & ~is_clear_i;

    assign alu_in = {bus.alu_rob_id, bus.alu_val};
    assign lsb_in = {bus.lsb_rob_id, bus.lsb_val};

    // A held loser always goes ahead of a fresh offer from the same source.
    assign cand_alu       = slot_alu_v | bus.alu_valid;
    assign cand_lsb       = slot_lsb_v | bus.lsb_valid;
    assign cand_alu_entry = slot_alu_v ? slot_alu_q : alu_in;
    assign cand_lsb_entry = slot_lsb_v ? slot_lsb_q : lsb_in;

    assign grant_alu = accept_en & cand_alu & (~cand_lsb | (rr_q == RR_ALU_FIRST));
    assign grant_lsb = accept_en & cand_lsb & (~cand_alu | (rr_q == RR_LSB_FIRST));

    // Ready looks only at slot occupancy and the grant (which uses valids),
    // never at the requester's own data.
    assign alu_ready = accept_en & (~slot_alu_v | grant_alu);
    assign lsb_ready = accept_en & (~slot_lsb_v | grant_lsb);

    assign alu_accept = bus.alu_valid & alu_ready;
    assign lsb_accept = bus.lsb_valid & lsb_ready;

    assign bus.alu_ready = alu_ready;
    assign bus.lsb_ready = lsb_ready;

    // An accepted offer is parked unless it went straight onto the bus.
    cdb_arbiter_slot #(.W(ENTRY_W)) u_slot_alu (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (rdy_i),
        .flush_i (is_clear_i),
        .load_i  (alu_accept & ~(grant_alu & ~slot_alu_v)),
        .drain_i (grant_alu & slot_alu_v),
        .d_i     (alu_in),
        .valid_o (slot_alu_v),
        .q_o     (slot_alu_q)
    );

    cdb_arbiter_slot #(.W(ENTRY_W)) u_slot_lsb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (rdy_i),
        .flush_i (is_clear_i),
        .load_i  (lsb_accept & ~(grant_lsb & ~slot_lsb_v)),
        .drain_i (grant_lsb & slot_lsb_v),
        .d_i     (lsb_in),
        .valid_o (slot_lsb_v),
        .q_o     (slot_lsb_q)
    );

    // Round-robin pointer: moves only when both sources competed and one won.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= RR_ALU_FIRST;
        end else if (rdy_i) begin
            rr_q <= rr_d;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if ((grant_alu | grant_lsb) & cand_alu & cand_lsb) begin
            rr_d = (rr_q == RR_ALU_FIRST) ? RR_LSB_FIRST : RR_ALU_FIRST;
        end
    end

    // Broadcast register; data holds its last value when nothing is granted.
    always_comb begin
        cdb_valid_d = grant_alu | grant_lsb;
        cdb_entry_d = cdb_entry_q;
        if (grant_alu) begin
            cdb_entry_d = cand_alu_entry;
        end else if (grant_lsb) begin
            cdb_entry_d = cand_lsb_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cdb_valid_q <= 1'b0;
            cdb_entry_q <= '0;
        end else if (rdy_i) begin
            cdb_valid_q <= cdb_valid_d;
            cdb_entry_q <= cdb_entry_d;
        end
    end

    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_val    = cdb_entry_q[DATA_W-1:0];
    assign bus.cdb_rob_id = cdb_entry_q[ENTRY_W-1:DATA_W];

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b0;
    logic is_clear = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    cdb_arbiter_if #(.DATA_W(32), .ROB_W(4)) bus ();

    cdb_arbiter #(.DATA_W(32), .ROB_W(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rdy_i      (rdy),
        .is_clear_i (is_clear),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: pending losers per source as queues, a "whose turn" bit,
    // and the expected broadcast after the coming edge.
    logic [35:0] mq_a[$];
    logic [35:0] mq_l[$];
    bit          fav_lsb = 1'b0;
    bit          e_ar, e_lr, e_cv;
    logic [31:0] e_cval = '0;
    logic [3:0]  e_cid  = '0;

    task automatic model_step();
        bit          en, ca, cl, wa, wl, a_empty, l_empty;
        logic [35:0] oa, ol, ea, el;
        oa = {bus.alu_rob_id, bus.alu_val};
        ol = {bus.lsb_rob_id, bus.lsb_val};
        a_empty = (mq_a.size() == 0);
        l_empty = (mq_l.size() == 0);
        en = rdy && !rst && !is_clear;
        ca = !a_empty || bus.alu_valid;
        cl = !l_empty || bus.lsb_valid;
        ea = a_empty ? oa : mq_a[0];
        el = l_empty ? ol : mq_l[0];
        if (ca && cl) begin
            wa = en && !fav_lsb;
            wl = en && fav_lsb;
        end else begin
            wa = en && ca;
            wl = en && cl;
        end
        e_ar = en && (a_empty || wa);
        e_lr = en && (l_empty || wl);
        if (rst) begin
            mq_a.delete(); mq_l.delete();
            fav_lsb = 1'b0; e_cv = 1'b0; e_cval = '0; e_cid = '0;
        end else if (!rdy) begin
            // everything frozen
        end else if (is_clear) begin
            mq_a.delete(); mq_l.delete();
            e_cv = 1'b0;
        end else begin
            e_cv = wa || wl;
            if (wa) begin e_cid = ea[35:32]; e_cval = ea[31:0]; end
            if (wl) begin e_cid = el[35:32]; e_cval = el[31:0]; end
            if (wa && !a_empty) void'(mq_a.pop_front());
            if (wl && !l_empty) void'(mq_l.pop_front());
            if (bus.alu_valid && e_ar && !(wa && a_empty)) mq_a.push_back(oa);
            if (bus.lsb_valid && e_lr && !(wl && l_empty)) mq_l.push_back(ol);
            if (ca && cl) fav_lsb = !fav_lsb;
        end
    endtask

    task automatic drive(input bit r, input bit rd, input bit clr,
                         input bit av, input logic [31:0] aval, input logic [3:0] aid,
                         input bit lv, input logic [31:0] lval, input logic [3:0] lid);
        rst = r; rdy = rd; is_clear = clr;
        bus.alu_valid = av; bus.alu_val = aval; bus.alu_rob_id = aid;
        bus.lsb_valid = lv; bus.lsb_val = lval; bus.lsb_rob_id = lid;
        #1;
        model_step();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 1, 0, 0, '0, '0, 0, '0, '0);
    endtask

    // Brings the tie-break back to ALU-first using only the model's view.
    task automatic ensure_alu_first();
        if (fav_lsb) begin
            drive(0, 1, 0, 1, 32'hC, 4'd12, 1, 32'hD, 4'd13);
            tick();
            idle(); tick();
            idle(); tick();
        end
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 0, '0, '0, 0, '0, '0); tick();
        drive(1, 1, 0, 0, '0, '0, 0, '0, '0); tick();
        idle();
        n_total++;
        if (bus.alu_ready !== 1'b1) $display("FAIL reset_alu_ready got %0b exp 1", bus.alu_ready);
        else n_pass++;
        n_total++;
        if (bus.lsb_ready !== 1'b1) $display("FAIL reset_lsb_ready got %0b exp 1", bus.lsb_ready);
        else n_pass++;
        n_total++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_rob_id !== 4'd0 || bus.cdb_val !== 32'd0)
            $display("FAIL reset_cdb got v=%0b id=%0d val=%h exp v=0 id=0 val=0",
                     bus.cdb_valid, bus.cdb_rob_id, bus.cdb_val);
        else n_pass++;
        tick();
        n_total++;
        if (bus.cdb_valid !== 1'b0) $display("FAIL idle_cdb_valid got %0b exp 0", bus.cdb_valid);
        else n_pass++;
    endtask

    task automatic test_single_alu();
        drive(0, 1, 0, 1, 32'h1234, 4'd3, 0, '0, '0);
        n_total++;
        if (bus.alu_ready !== 1'b1) $display("FAIL single_alu_ready got %0b exp 1", bus.alu_ready);
        else n_pass++;
        tick();
        idle();
        n_total++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_val !== 32'h1234 || bus.cdb_rob_id !== 4'd3)
            $display("FAIL single_cdb got v=%0b id=%0d val=%h exp v=1 id=3 val=1234",
                     bus.cdb_valid, bus.cdb_rob_id, bus.cdb_val);
        else n_pass++;
        tick();
        n_total++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_val !== 32'h1234)
            $display("FAIL single_after got v=%0b val=%h exp v=0 val=1234 held",
                     bus.cdb_valid, bus.cdb_val);
        else n_pass++;
    endtask

    task automatic test_contention();
        ensure_alu_first();
        drive(0, 1, 0, 1, 32'hA, 4'd1, 1, 32'hB, 4'd2);
        n_total++;
        if (bus.alu_ready !== 1'b1 || bus.lsb_ready !== 1'b1)
            $display("FAIL contend_ready got a=%0b l=%0b exp a=1 l=1", bus.alu_ready, bus.lsb_ready);
        else n_pass++;
        tick();
        idle();
        n_total++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_id !== 4'd1 || bus.cdb_val !== 32'hA)
            $display("FAIL contend_first got v=%0b id=%0d val=%h exp v=1 id=1 val=a",
                     bus.cdb_valid, bus.cdb_rob_id, bus.cdb_val);
        else n_pass++;
        tick();
        n_total++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_id !== 4'd2 || bus.cdb_val !== 32'hB)
            $display("FAIL contend_second got v=%0b id=%0d val=%h exp v=1 id=2 val=b",
                     bus.cdb_valid, bus.cdb_rob_id, bus.cdb_val);
        else n_pass++;
        // Pointer now favours the LSB.
        drive(0, 1, 0, 1, 32'h4, 4'd4, 1, 32'h5, 4'd5);
        tick();
        idle();
        n_total++;
        if (bus.cdb_rob_id !== 4'd5) $display("FAIL contend_rr_lsb got id=%0d exp 5", bus.cdb_rob_id);
        else n_pass++;
        tick();
        n_total++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_id !== 4'd4)
            $display("FAIL contend_rr_alu got v=%0b id=%0d exp v=1 id=4", bus.cdb_valid, bus.cdb_rob_id);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int   acc_a[$], acc_l[$], bc[$], fa[$], fl[$];
        bit   ra[16], rl[16];
        bit   pa, pl;
        logic [3:0] ia, il;
        int   na, nl;
        ensure_alu_first();
        pa = 0; pl = 0; na = 1; nl = 2; ia = '0; il = '0;
        for (int c = 0; c < 16; c++) begin
            if (!pa && c < 6) begin pa = 1; ia = 4'(na); na += 2; end
            if (!pl && c < 6) begin pl = 1; il = 4'(nl); nl += 2; end
            drive(0, 1, 0, pa, {28'h0, ia}, ia, pl, {28'h0, il}, il);
            ra[c] = bus.alu_ready; rl[c] = bus.lsb_ready;
            n_total++;
            if (bus.alu_ready !== e_ar || bus.lsb_ready !== e_lr)
                $display("FAIL b2b_ready c=%0d got a=%0b l=%0b exp a=%0b l=%0b",
                         c, bus.alu_ready, bus.lsb_ready, e_ar, e_lr);
            else n_pass++;
            if (pa && e_ar) begin acc_a.push_back(int'(ia)); pa = 0; end
            if (pl && e_lr) begin acc_l.push_back(int'(il)); pl = 0; end
            tick();
            n_total++;
            if (bus.cdb_valid !== e_cv || (e_cv && bus.cdb_rob_id !== e_cid))
                $display("FAIL b2b_cdb c=%0d got v=%0b id=%0d exp v=%0b id=%0d",
                         c, bus.cdb_valid, bus.cdb_rob_id, e_cv, e_cid);
            else n_pass++;
            if (bus.cdb_valid === 1'b1) bc.push_back(int'(bus.cdb_rob_id));
        end
        for (int c = 3; c < 6; c++) begin
            n_total++;
            if (ra[c] == ra[c-1] || rl[c] == rl[c-1] || ra[c] == rl[c])
                $display("FAIL b2b_alternate_ready c=%0d got a=%0b l=%0b prev a=%0b l=%0b",
                         c, ra[c], rl[c], ra[c-1], rl[c-1]);
            else n_pass++;
        end
        n_total++;
        if (bc.size() != acc_a.size() + acc_l.size())
            $display("FAIL b2b_count got %0d exp %0d", bc.size(), acc_a.size() + acc_l.size());
        else n_pass++;
        for (int i = 0; i < bc.size(); i++) begin
            if (bc[i] % 2 == 1) fa.push_back(bc[i]);
            else fl.push_back(bc[i]);
        end
        n_total++;
        if (fa != acc_a || fl != acc_l)
            $display("FAIL b2b_order got alu_n=%0d lsb_n=%0d exp alu_n=%0d lsb_n=%0d",
                     fa.size(), fl.size(), acc_a.size(), acc_l.size());
        else n_pass++;
        for (int i = 1; i < 6 && i < bc.size(); i++) begin
            n_total++;
            if ((bc[i] % 2) == (bc[i-1] % 2))
                $display("FAIL b2b_alternate_cdb i=%0d got id=%0d prev id=%0d exp other source",
                         i, bc[i], bc[i-1]);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        ensure_alu_first();
        drive(0, 1, 0, 1, 32'h66, 4'd6, 1, 32'h55, 4'd5);
        tick();
        drive(0, 1, 1, 1, 32'h88, 4'd8, 0, '0, '0);
        n_total++;
        if (bus.alu_ready !== 1'b0 || bus.lsb_ready !== 1'b0)
            $display("FAIL flush_ready got a=%0b l=%0b exp a=0 l=0", bus.alu_ready, bus.lsb_ready);
        else n_pass++;
        tick();
        n_total++;
        if (bus.cdb_valid !== 1'b0) $display("FAIL flush_cdb_valid got %0b exp 0", bus.cdb_valid);
        else n_pass++;
        idle();
        n_total++;
        if (bus.alu_ready !== 1'b1 || bus.lsb_ready !== 1'b1)
            $display("FAIL flush_after_ready got a=%0b l=%0b exp a=1 l=1", bus.alu_ready, bus.lsb_ready);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            idle();
            n_total++;
            if (bus.cdb_valid !== 1'b0)
                $display("FAIL flush_leak c=%0d got v=%0b id=%0d exp v=0", c, bus.cdb_valid, bus.cdb_rob_id);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        ensure_alu_first();
        drive(0, 1, 0, 1, 32'h77, 4'd7, 1, 32'hAA, 4'd10);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, '0, '0, 0, '0, '0);
            n_total++;
            if (bus.alu_ready !== 1'b0 || bus.lsb_ready !== 1'b0)
                $display("FAIL stall_ready c=%0d got a=%0b l=%0b exp 0 0", c, bus.alu_ready, bus.lsb_ready);
            else n_pass++;
            tick();
            n_total++;
            if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_id !== 4'd7 || bus.cdb_val !== 32'h77)
                $display("FAIL stall_hold c=%0d got v=%0b id=%0d val=%h exp v=1 id=7 val=77",
                         c, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_val);
            else n_pass++;
        end
        idle();
        tick();
        n_total++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_id !== 4'd10 || bus.cdb_val !== 32'hAA)
            $display("FAIL stall_resume got v=%0b id=%0d val=%h exp v=1 id=10 val=aa",
                     bus.cdb_valid, bus.cdb_rob_id, bus.cdb_val);
        else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_random();
        bit          pa, pl, rd, clr;
        logic [31:0] va, vl;
        logic [3:0]  ia, il;
        pa = 0; pl = 0; va = '0; vl = '0; ia = '0; il = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pa && $urandom_range(99) < 60) begin pa = 1; va = $urandom; ia = 4'($urandom); end
            if (!pl && $urandom_range(99) < 60) begin pl = 1; vl = $urandom; il = 4'($urandom); end
            rd  = ($urandom_range(99) >= 10);
            clr = ($urandom_range(99) < 4);
            drive(0, rd, clr, pa, va, ia, pl, vl, il);
            n_total++;
            if (bus.alu_ready !== e_ar || bus.lsb_ready !== e_lr)
                $display("FAIL rand_ready c=%0d got a=%0b l=%0b exp a=%0b l=%0b",
                         c, bus.alu_ready, bus.lsb_ready, e_ar, e_lr);
            else n_pass++;
            if (pa && e_ar) pa = 0;
            if (pl && e_lr) pl = 0;
            // A flush discards the producers' in-flight offers as well.
            if (rd && clr) begin pa = 0; pl = 0; end
            tick();
            n_total++;
            if (bus.cdb_valid !== e_cv || bus.cdb_rob_id !== e_cid || bus.cdb_val !== e_cval)
                $display("FAIL rand_cdb c=%0d got v=%0b id=%0d val=%h exp v=%0b id=%0d val=%h",
                         c, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_val, e_cv, e_cid, e_cval);
            else n_pass++;
        end
    endtask

    initial begin
        bus.alu_valid = 0; bus.alu_val = '0; bus.alu_rob_id = '0;
        bus.lsb_valid = 0; bus.lsb_val = '0; bus.lsb_rob_id = '0;
        test_reset();
        test_single_alu();
        test_contention();
        test_back_to_back();
        test_flush();
        test_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the single common data bus (CDB) between the two result producers, the ALU and the load/store buffer. The CDB feeds the dispatcher's operand-forwarding compare, the reservation station, the LSB and the ROB.
Each source has a 1-entry holding slot, so a loser of arbitration is not lost. A round-robin pointer guarantees fairness. Results appear on the CDB registered, one cycle after the winning request.

Parameters:
DATA_W, 32, result value width
ROB_W, 4, ROB tag width (16-entry ROB)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state
is_clear  in  1  misprediction flush from ROB
alu_valid  in  1  ALU result offered this cycle
alu_val  in  DATA_W  ALU result value
alu_rob_id  in  ROB_W  ROB tag of ALU result
alu_ready  out  1  arbiter accepts ALU offer this cycle (combinational)
lsb_valid  in  1  LSB load result offered
lsb_val  in  DATA_W  load value
lsb_rob_id  in  ROB_W  ROB tag of load
lsb_ready  out  1  arbiter accepts LSB offer this cycle (combinational)
cdb_valid  out  1  broadcast valid (registered)
cdb_val  out  DATA_W  broadcast value (registered)
cdb_rob_id  out  ROB_W  broadcast ROB tag (registered)

Behaviour:
- Reset (rst=1 at posedge): slots empty, cdb_valid=0, cdb_val=0, cdb_rob_id=0, rr pointer = ALU-first. Reset dominates rdy and is_clear.
- rdy=0: no state changes; cdb_* hold their values; alu_ready=lsb_ready=0.
- Candidate per source X:
  - slot_X if slot_X is occupied;
  - else the incoming offer if X_valid;
  - else none.
- Grant:
  - If exactly one candidate exists, it wins.
  - If two exist, the source the rr pointer favours wins; the pointer then flips to favour the other source.
  - A single-candidate grant leaves the pointer unchanged.
- Output: at the next posedge, cdb_valid=1 and cdb_val/cdb_rob_id = winner's data. With no candidate, cdb_valid=0 and data holds its previous value.
- Latency: 1 cycle from offer to CDB when uncontended and the slot is empty.
- X_ready = rdy & !rst & !is_clear & (slot_X empty | slot_X granted this cycle).
- Slot update on accept (X_valid & X_ready):
  - Incoming offer won directly: slot stays empty.
  - Otherwise: the offer is written into slot_X.
- Slot granted and no new accept: slot_X empties.
- Slot full and not granted: X_ready=0; the source must hold its offer (valid/data stable until ready).
- is_clear=1 (with rdy): at the posedge, both slots empty, cdb_valid=0, rr pointer unchanged. Offers in that cycle are not accepted.
- ready must not depend combinationally on the requester's own data. ready may depend on both valids; sources must not derive valid from ready.
- No result is ever duplicated or dropped outside a clear.

Decomposition:
- Shared macros header: CDB field widths and ROB tag width, next to the existing opcode macros. Add a `CDB_ENTRY` width macro (DATA_W+ROB_W).
- One natural sub-module: cdb_slot (1-entry holding register with valid, load, drain and flush), instantiated twice.
- The round-robin pick stays in the top module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all valids 0 → cdb_valid=0, cdb_rob_id=0, both ready=1.
- Single ALU: alu_valid=1, val=0x1234, id=3 for 1 cycle → alu_ready=1; next cycle cdb_valid=1, val=0x1234, id=3; cycle after, cdb_valid=0.
- Contention: both valid in the same cycle (ALU 0xA/id1, LSB 0xB/id2), rr pointer at reset value (ALU-first) → cycle+1 CDB=id1, cycle+2 CDB=id2. LSB is accepted into its slot (lsb_ready=1 at cycle 0). Pointer then favours LSB.
- Back-to-back saturation: both valid every cycle for 6 cycles with distinct ids → CDB alternates sources each cycle. Each source's ready is 1 on alternate cycles, no id lost or repeated, order per source preserved.
- Flush: LSB slot holding id5, is_clear=1 → next cycle cdb_valid=0, id5 never broadcast, both ready=1 the following cycle.
- Stall: rdy=0 for 3 cycles while CDB shows id7 → cdb_* unchanged, ready=0. On rdy=1, pending slot data is broadcast next cycle.
